disp_fifo: RTL and testbench

//  Single-clock pixel buffer directly downstream of the AXI display read controller.

---
 rtl/disp_fifo.sv | 124 ++++++++++++
 tb/tb_disp_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/disp_fifo.sv
// disp_fifo
//   Single-clock pixel buffer sitting directly behind the AXI display read
//   controller. Every R-channel beat is captured because the controller ties
//   RREADY to RVALID and cannot be back-pressured. The pixel-output stage pops
//   24-bit RGB words with one cycle of read latency.
//
// Parameters
//   DATA_W       R-channel data width; word = {pad, R[7:0], G[7:0], B[7:0]}
//   DEPTH        storage words, power of 2, at least 2*BURST_WORDS
//   BURST_WORDS  beats per AXI burst
//
// Ports
//   ACLK       in   clock, rising edge
//   ARST       in   synchronous active-high reset
//   RDATA      in   AXI read data
//   RVALID     in   beat present
//   RREADY     in   controller's ready (observed only)
//   FIFOREADY  out  room for one more complete burst
//   FLUSH      in   frame-start clear pulse
//   PIXRD      in   pop request from the pixel stage
//   PIXDATA    out  popped pixel {R,G,B}
//   PIXVALID   out  PIXDATA was updated this cycle
//   LEVEL      out  number of stored words
//   OVERFLOW   out  sticky: beat arrived while full
//   UNDERFLOW  out  sticky: pop requested while empty

module disp_fifo #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 128,
  parameter int BURST_WORDS = 32,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RVALID,
  input  logic              RREADY,
  output logic              FIFOREADY,
  input  logic              FLUSH,
  input  logic              PIXRD,
  output logic [23:0]       PIXDATA,
  output logic              PIXVALID,
  output logic [PTR_W:0]    LEVEL,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam logic [PTR_W:0] FULL_LEVEL  = (PTR_W+1)'(DEPTH);
  // The controller samples FIFOREADY on RLAST before that beat is counted,
  // hence the extra word of margin below one full burst of headroom.
  localparam logic [PTR_W:0] READY_LIMIT = (PTR_W+1)'(DEPTH - BURST_WORDS - 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level;
  logic [23:0]      mem [DEPTH];

  logic wr_req;
  logic pop;
  logic wr_ok;
  logic mem_we;

  // Only the RGB bytes are stored; the pad byte of each beat is dropped here.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^RDATA[DATA_W-1:24];

  assign wr_req = RVALID & RREADY;
  assign pop    = PIXRD & (level != '0);
  // When full, a same-cycle pop frees the slot at rd_ptr (== wr_ptr) and the
  // RAM's read-before-write behaviour returns the old word to the reader.
  assign wr_ok  = wr_req & ((level != FULL_LEVEL) | pop);
  assign mem_we = wr_ok & ~FLUSH & ~ARST;

  // Storage array kept free of reset so it maps onto a simple dual-port RAM.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      mem[wr_ptr] <= RDATA[23:0];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      PIXDATA   <= '0;
      PIXVALID  <= 1'b0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else if (FLUSH) begin
      // Frame start: discard everything, but leave the last pixel on PIXDATA.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      PIXVALID  <= 1'b0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      PIXVALID <= pop;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        PIXDATA <= mem[rd_ptr];
      end
      case ({wr_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_req & ~wr_ok) begin
        OVERFLOW <= 1'b1;
      end
      if (PIXRD & (level == '0)) begin
        UNDERFLOW <= 1'b1;
      end
    end
  end

  assign LEVEL     = level;
  assign FIFOREADY = (level <= READY_LIMIT);

endmodule

// File: tb/tb_disp_fifo.sv
// tb_disp_fifo
//   Self-checking bench for disp_fifo. A queue of expected pixels is filled
//   as beats are driven and drained as pops complete; flags, LEVEL and
//   FIFOREADY are predicted from that queue every cycle.

module tb_disp_fifo;

  localparam int DEPTH = 128;
  localparam int BURST = 32;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic        FIFOREADY;
  logic        FLUSH;
  logic        PIXRD;
  logic [23:0] PIXDATA;
  logic        PIXVALID;
  logic [7:0]  LEVEL;
  logic        OVERFLOW;
  logic        UNDERFLOW;

  disp_fifo #(.DATA_W(32), .DEPTH(DEPTH), .BURST_WORDS(BURST)) dut (
    .ACLK(ACLK), .ARST(ARST), .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .FIFOREADY(FIFOREADY), .FLUSH(FLUSH), .PIXRD(PIXRD), .PIXDATA(PIXDATA),
    .PIXVALID(PIXVALID), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int passed = 0;
  int validCount = 0;

  logic [23:0] sbQueue[$];
  logic [23:0] mdlPixData;
  logic        mdlValid;
  logic        mdlOvf;
  logic        mdlUnf;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic checkState();
    checkOutput("level", 32'(LEVEL), 32'(sbQueue.size()));
    checkOutput("fifoready", 32'(FIFOREADY), 32'(sbQueue.size() <= DEPTH - BURST - 1));
    checkOutput("pixvalid", 32'(PIXVALID), 32'(mdlValid));
    checkOutput("pixdata", 32'(PIXDATA), 32'(mdlPixData));
    checkOutput("overflow", 32'(OVERFLOW), 32'(mdlOvf));
    checkOutput("underflow", 32'(UNDERFLOW), 32'(mdlUnf));
  endtask

  // One clock of stimulus: predict, apply the edge, pop the scoreboard, compare.
  task automatic applyStimulus(input logic rv, input logic rr, input logic [31:0] data,
                               input logic rd, input logic flush);
    logic expPop;
    RVALID = rv;
    RREADY = rr;
    RDATA  = data;
    PIXRD  = rd;
    FLUSH  = flush;
    expPop = 1'b0;
    if (flush) begin
      sbQueue.delete();
      mdlOvf = 1'b0;
      mdlUnf = 1'b0;
    end else begin
      expPop = rd && (sbQueue.size() != 0);
      if (rd && sbQueue.size() == 0) mdlUnf = 1'b1;
      if (rv && rr) begin
        if (sbQueue.size() < DEPTH || expPop) sbQueue.push_back(data[23:0]);
        else mdlOvf = 1'b1;
      end
    end
    @(posedge ACLK);
    #1;
    mdlValid = expPop;
    if (expPop) mdlPixData = sbQueue.pop_front();
    if (PIXVALID) validCount++;
    checkState();
  endtask

  task automatic applyReset(input logic inFlight);
    ARST   = 1'b1;
    RVALID = inFlight;
    RREADY = inFlight;
    RDATA  = 32'h00DEAD00;
    PIXRD  = inFlight;
    FLUSH  = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARST = 1'b0;
    sbQueue.delete();
    mdlPixData = '0;
    mdlValid   = 1'b0;
    mdlOvf     = 1'b0;
    mdlUnf     = 1'b0;
    checkState();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic writeBeat(input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, data, 1'b0, 1'b0);
  endtask

  task automatic popWord();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    ARST = 1'b1; RVALID = 1'b0; RREADY = 1'b0; RDATA = '0; PIXRD = 1'b0; FLUSH = 1'b0;
    mdlPixData = '0; mdlValid = 1'b0; mdlOvf = 1'b0; mdlUnf = 1'b0;

    // Reset with no traffic.
    applyReset(1'b0);
    checkOutput("reset_level", 32'(LEVEL), 32'd0);
    checkOutput("reset_ready", 32'(FIFOREADY), 32'd1);
    idle(2);

    // One burst of 0..31, then 32 pops; the pad byte must be stripped.
    for (int i = 0; i < 32; i++) writeBeat(32'hFF00_0000 | 32'(i));
    validCount = 0;
    for (int i = 0; i < 32; i++) popWord();
    idle(2);
    checkOutput("burst_valid_count", 32'(validCount), 32'd32);
    checkOutput("burst_last_pixel", 32'(PIXDATA), 32'h0000_001F);
    checkOutput("burst_level", 32'(LEVEL), 32'd0);

    // FIFOREADY threshold at 95/96 words.
    for (int i = 0; i < 95; i++) writeBeat($urandom);
    checkOutput("ready_at_95", 32'(FIFOREADY), 32'd1);
    writeBeat($urandom);
    checkOutput("ready_at_96", 32'(FIFOREADY), 32'd0);
    popWord();
    checkOutput("ready_after_pop", 32'(FIFOREADY), 32'd1);

    // Fill to DEPTH, then simultaneous write+pop, then a refused write.
    for (int i = 0; i < 33; i++) writeBeat($urandom);
    checkOutput("full_level", 32'(LEVEL), 32'd128);
    applyStimulus(1'b1, 1'b1, 32'h00123456, 1'b1, 1'b0);
    checkOutput("full_rw_level", 32'(LEVEL), 32'd128);
    checkOutput("full_rw_ovf", 32'(OVERFLOW), 32'd0);
    writeBeat(32'h00BADBAD);
    checkOutput("full_w_ovf", 32'(OVERFLOW), 32'd1);

    // Drain, then pop while empty with a same-cycle write.
    for (int i = 0; i < DEPTH; i++) popWord();
    applyStimulus(1'b1, 1'b1, 32'h11AABBCC, 1'b1, 1'b0);
    checkOutput("empty_unf", 32'(UNDERFLOW), 32'd1);
    checkOutput("empty_valid", 32'(PIXVALID), 32'd0);
    popWord();
    checkOutput("empty_next_pixel", 32'(PIXDATA), 32'h00AABBCC);

    // Flush mid-burst at LEVEL=40 with both flags set; the beat is dropped.
    for (int i = 0; i < 40; i++) writeBeat(32'h0000_1000 + 32'(i));
    checkOutput("pre_flush_level", 32'(LEVEL), 32'd40);
    applyStimulus(1'b1, 1'b1, 32'h0000_0BAD, 1'b1, 1'b1);
    checkOutput("flush_level", 32'(LEVEL), 32'd0);
    checkOutput("flush_flags", 32'({OVERFLOW, UNDERFLOW}), 32'd0);
    for (int i = 0; i < 3; i++) writeBeat(32'h0000_2000 + 32'(i));
    for (int i = 0; i < 3; i++) popWord();
    checkOutput("post_flush_pixel", 32'(PIXDATA), 32'h0000_2002);

    // Random traffic with phases biased toward full and empty, one reset mid-way.
    for (int i = 0; i < 600; i++) begin
      logic rv, rr, rd, fl;
      int wrBias;
      wrBias = ((i / 100) % 2 == 0) ? 85 : 15;
      rv = ($urandom_range(99) < wrBias);
      rr = rv ? ($urandom_range(9) != 0) : 1'b0;
      rd = ($urandom_range(99) < 100 - wrBias);
      fl = ($urandom_range(79) == 0);
      if (i == 300) applyReset(1'b1);
      else applyStimulus(rv, rr, $urandom, rd, fl);
    end
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
